// File: rtl/topk_tracker_if.sv
// Sample-stream and read-port bundle for topk_tracker; master drives samples and rank_sel.
// Slave (the tracker) returns the sorted table, per-slot valid bits and the ranked read value.
interface topk_tracker_if #(
  parameter int DATA_WIDTH = 32,
  parameter int K          = 4
);
  localparam int RW = (K > 1) ? $clog2(K) : 1;
  localparam int OW = $clog2(K + 1);

  logic                    din_valid;
  logic [DATA_WIDTH-1:0]   din;
  logic                    clear;
  logic [RW-1:0]           rank_sel;
  logic [DATA_WIDTH-1:0]   dout;
  logic                    dout_valid;
  logic [K*DATA_WIDTH-1:0] topk;
  logic [K-1:0]            topk_valid;
  logic [OW-1:0]           occupancy;

  modport master (
    output din_valid, din, clear, rank_sel,
    input  dout, dout_valid, topk, topk_valid, occupancy
  );

  modport slave (
    input  din_valid, din, clear, rank_sel,
    output dout, dout_valid, topk, topk_valid, occupancy
  );
endinterface

// File: rtl/topk_tracker.sv
// Top-K tracker: descending table of the K largest samples; a sample lands one edge later.
// One sample per cycle with no backpressure; read port is combinational from the table.
module topk_tracker #(
  parameter int DATA_WIDTH = 32,
  parameter int K          = 4,
  parameter int SIGNED     = 0,
  parameter int UNIQUE     = 0
) (
  input  logic          clk,
  input  logic          reset,
  topk_tracker_if.slave bus
);
  localparam int OW = $clog2(K + 1);

  logic [DATA_WIDTH-1:0] slot   [K];
  logic [DATA_WIDTH-1:0] slot_n [K];
  logic [K-1:0]          vld, vld_n;
  logic [K-1:0]          ge_v;
  logic                  dup, accept;
  logic [OW-1:0]         occ;

  function automatic logic ge(input logic [DATA_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] b);
    if (SIGNED != 0) return $signed(a) >= $signed(b);
    else             return a >= b;
  endfunction

  // Table is sorted and valid-contiguous, so ge_v is a prefix of ones; its length is the insert point.
  always_comb begin
    dup = 1'b0;
    for (int i = 0; i < K; i++) begin
      ge_v[i] = vld[i] && ge(slot[i], bus.din);
      dup     = dup | (vld[i] && (slot[i] == bus.din));
    end
    accept = bus.din_valid && !((UNIQUE != 0) && dup);

    for (int i = 0; i < K; i++) slot_n[i] = slot[i];
    vld_n = vld;

    if (bus.clear) begin
      for (int i = 0; i < K; i++) slot_n[i] = '0;
      vld_n = '0;
      if (bus.din_valid) begin
        slot_n[0] = bus.din;
        vld_n[0]  = 1'b1;
      end
    end else if (accept) begin
      // Appending a one keeps valid contiguous; a full table stays all ones.
      vld_n = {vld[K-2:0], 1'b1};
      if (!ge_v[0]) slot_n[0] = bus.din;
      for (int i = 1; i < K; i++) begin
        if (!ge_v[i]) slot_n[i] = ge_v[i-1] ? bus.din : slot[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < K; i++) slot[i] <= '0;
      vld <= '0;
    end else begin
      for (int i = 0; i < K; i++) slot[i] <= slot_n[i];
      vld <= vld_n;
    end
  end

  always_comb begin
    occ = '0;
    for (int i = 0; i < K; i++) occ = occ + OW'(vld[i]);
  end

  always_comb begin
    for (int i = 0; i < K; i++) bus.topk[i*DATA_WIDTH +: DATA_WIDTH] = slot[i];
  end

  assign bus.topk_valid = vld;
  assign bus.occupancy  = occ;
  // Guards rank_sel codes beyond K-1 when K is not a power of two.
  assign bus.dout       = (32'(bus.rank_sel) < 32'(K)) ? slot[bus.rank_sel] : '0;
  assign bus.dout_valid = (32'(bus.rank_sel) < 32'(K)) ? vld[bus.rank_sel] : 1'b0;
endmodule

// File: tb/tb_topk_tracker.sv
// Four tracker configurations share one stimulus stream; a scoreboard model predicts each table.
module tb_topk_tracker;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        din_valid = 1'b0;
  logic [31:0] din = '0;
  logic        clear = 1'b0;
  logic [1:0]  rank_sel = '0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // d0: 32b K4 unsigned, d1: 32b K4 unique, d2: 8b K4 signed, d3: 8b K3 unsigned
  topk_tracker_if #(.DATA_WIDTH(32), .K(4)) if0 ();
  topk_tracker_if #(.DATA_WIDTH(32), .K(4)) if1 ();
  topk_tracker_if #(.DATA_WIDTH(8),  .K(4)) if2 ();
  topk_tracker_if #(.DATA_WIDTH(8),  .K(3)) if3 ();

  assign if0.din_valid = din_valid; assign if0.din = din;      assign if0.clear = clear; assign if0.rank_sel = rank_sel;
  assign if1.din_valid = din_valid; assign if1.din = din;      assign if1.clear = clear; assign if1.rank_sel = rank_sel;
  assign if2.din_valid = din_valid; assign if2.din = din[7:0]; assign if2.clear = clear; assign if2.rank_sel = rank_sel;
  assign if3.din_valid = din_valid; assign if3.din = din[7:0]; assign if3.clear = clear; assign if3.rank_sel = rank_sel;

  topk_tracker #(.DATA_WIDTH(32), .K(4), .SIGNED(0), .UNIQUE(0)) u0 (.clk(clk), .reset(reset), .bus(if0));
  topk_tracker #(.DATA_WIDTH(32), .K(4), .SIGNED(0), .UNIQUE(1)) u1 (.clk(clk), .reset(reset), .bus(if1));
  topk_tracker #(.DATA_WIDTH(8),  .K(4), .SIGNED(1), .UNIQUE(0)) u2 (.clk(clk), .reset(reset), .bus(if2));
  topk_tracker #(.DATA_WIDTH(8),  .K(3), .SIGNED(0), .UNIQUE(0)) u3 (.clk(clk), .reset(reset), .bus(if3));

  logic [127:0] got_topk [4];
  logic [3:0]   got_vld  [4];
  int           got_occ  [4];
  logic [31:0]  got_dout [4];
  logic         got_dv   [4];

  always_comb begin
    got_topk[0] = 128'(if0.topk); got_vld[0] = if0.topk_valid;       got_occ[0] = int'(if0.occupancy);
    got_topk[1] = 128'(if1.topk); got_vld[1] = if1.topk_valid;       got_occ[1] = int'(if1.occupancy);
    got_topk[2] = 128'(if2.topk); got_vld[2] = if2.topk_valid;       got_occ[2] = int'(if2.occupancy);
    got_topk[3] = 128'(if3.topk); got_vld[3] = {1'b0, if3.topk_valid}; got_occ[3] = int'(if3.occupancy);
    got_dout[0] = if0.dout;        got_dv[0] = if0.dout_valid;
    got_dout[1] = if1.dout;        got_dv[1] = if1.dout_valid;
    got_dout[2] = 32'(if2.dout);   got_dv[2] = if2.dout_valid;
    got_dout[3] = 32'(if3.dout);   got_dv[3] = if3.dout_valid;
  end

  // Reference model
  int cfg_w [4] = '{32, 32, 8, 8};
  int cfg_k [4] = '{4, 4, 4, 3};
  bit cfg_s [4] = '{0, 0, 1, 0};
  bit cfg_u [4] = '{0, 1, 0, 0};

  logic [31:0] m_slot [4][4];
  int          m_n    [4];

  typedef struct {
    int           dut;
    logic [127:0] topk;
    logic [3:0]   vld;
    int           occ;
  } exp_t;
  exp_t sb [$];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mask(input int d, input logic [31:0] v);
    return (cfg_w[d] == 8) ? {24'h0, v[7:0]} : v;
  endfunction

  function automatic bit m_ge(input int d, input logic [31:0] a, input logic [31:0] b);
    logic [7:0] a8, b8;
    a8 = a[7:0];
    b8 = b[7:0];
    if (cfg_w[d] == 8) return cfg_s[d] ? ($signed(a8) >= $signed(b8)) : (a8 >= b8);
    return cfg_s[d] ? ($signed(a) >= $signed(b)) : (a >= b);
  endfunction

  function automatic void m_reset();
    for (int d = 0; d < 4; d++) begin
      m_n[d] = 0;
      for (int i = 0; i < 4; i++) m_slot[d][i] = '0;
    end
  endfunction

  function automatic void m_step(input bit v, input logic [31:0] x, input bit c);
    for (int d = 0; d < 4; d++) begin
      logic [31:0] dm;
      bit seen;
      int p;
      dm = mask(d, x);
      if (c) begin
        m_n[d] = 0;
        for (int i = 0; i < 4; i++) m_slot[d][i] = '0;
        if (v) begin
          m_slot[d][0] = dm;
          m_n[d] = 1;
        end
      end else if (v) begin
        seen = 0;
        p = 0;
        for (int i = 0; i < m_n[d]; i++) begin
          if (m_slot[d][i] == dm) seen = 1;
          if (m_ge(d, m_slot[d][i], dm)) p++;
        end
        if (!(cfg_u[d] && seen) && p < cfg_k[d]) begin
          for (int i = cfg_k[d] - 1; i > p; i--) m_slot[d][i] = m_slot[d][i-1];
          m_slot[d][p] = dm;
          if (m_n[d] < cfg_k[d]) m_n[d]++;
        end
      end
    end
  endfunction

  function automatic void push_expect();
    for (int d = 0; d < 4; d++) begin
      exp_t e;
      e.dut = d;
      e.topk = '0;
      e.vld = '0;
      for (int i = 0; i < cfg_k[d]; i++)
        for (int b = 0; b < cfg_w[d]; b++) e.topk[i*cfg_w[d] + b] = m_slot[d][i][b];
      for (int i = 0; i < m_n[d]; i++) e.vld[i] = 1'b1;
      e.occ = m_n[d];
      sb.push_back(e);
    end
  endfunction

  task automatic pop_check(input string tag);
    while (sb.size() > 0) begin
      exp_t e;
      int d, r;
      e = sb.pop_front();
      d = e.dut;
      r = int'(rank_sel);
      check($sformatf("%s d%0d topk", tag, d), got_topk[d], e.topk);
      check($sformatf("%s d%0d valid", tag, d), 128'(got_vld[d]), 128'(e.vld));
      check($sformatf("%s d%0d occ", tag, d), 128'(got_occ[d]), 128'(e.occ));
      check($sformatf("%s d%0d dout r%0d", tag, d, r), 128'(got_dout[d]),
            (r < cfg_k[d]) ? 128'(m_slot[d][r]) : 128'(0));
      check($sformatf("%s d%0d dout_valid r%0d", tag, d, r), 128'(got_dv[d]), 128'(r < m_n[d]));
    end
  endtask

  task automatic drive(input string tag, input bit v, input logic [31:0] x, input bit c);
    din_valid = v;
    din = x;
    clear = c;
    m_step(v, x, c);
    push_expect();
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    clear = 1'b0;
    pop_check(tag);
  endtask

  initial begin
    logic [31:0] s1 [5] = '{32'd5, 32'd9, 32'd2, 32'd9, 32'd7};
    logic [31:0] s2 [3] = '{32'hFF, 32'h01, 32'h80};
    logic [31:0] s3 [4] = '{32'd9, 32'd7, 32'd5, 32'd2};

    m_reset();
    repeat (2) @(posedge clk);
    #1;
    push_expect();
    pop_check("reset");
    reset = 1'b0;

    foreach (s1[i]) drive("stream1", 1'b1, s1[i], 1'b0);
    drive("below_min", 1'b1, 32'd3, 1'b0);
    drive("ins8", 1'b1, 32'd8, 1'b0);

    drive("clear_alone", 1'b0, '0, 1'b1);
    foreach (s2[i]) drive("signed_mix", 1'b1, s2[i], 1'b0);

    drive("clear2", 1'b0, '0, 1'b1);
    drive("zero", 1'b1, 32'd0, 1'b0);
    for (int r = 0; r < 4; r++) begin
      rank_sel = 2'(r);
      drive("zero_rank", 1'b0, '0, 1'b0);
    end
    rank_sel = 2'd0;

    drive("clear3", 1'b0, '0, 1'b1);
    foreach (s3[i]) drive("fill", 1'b1, s3[i], 1'b0);
    drive("clear_din", 1'b1, 32'd3, 1'b1);
    drive("clear4", 1'b0, '0, 1'b1);

    foreach (s3[i]) drive("prefill", 1'b1, s3[i], 1'b0);
    #3;
    reset = 1'b1;
    #1;
    m_reset();
    push_expect();
    pop_check("async_reset");
    @(negedge clk);
    reset = 1'b0;
    drive("post_reset4", 1'b1, 32'd4, 1'b0);
    drive("post_reset6", 1'b1, 32'd6, 1'b0);
    rank_sel = 2'd3;
    drive("rank3", 1'b0, '0, 1'b0);

    for (int n = 0; n < 300; n++) begin
      logic [31:0] x;
      x = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) : 32'($urandom_range(120, 136));
      rank_sel = 2'($urandom_range(0, 3));
      drive("random", $urandom_range(0, 4) != 0, x, $urandom_range(0, 40) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
